// File: rtl/uop_fetch_queue.sv
// -----------------------------------------------------------------------------
// uop_fetch_queue
//
// Purpose:
//   Sequences a microcode routine out of the uop buffer, FETCH_WIDTH uops per
//   cycle, into a DEPTH-entry bundle queue. Bundles are handed to decode over
//   a valid/ready handshake. The block supports routine start, end-of-routine
//   detection, redirect (flush plus a new fetch address) and natural
//   wrap-around of the uop buffer address.
//
// Parameters:
//   FETCH_WIDTH   uops per bundle (1..8)
//   DEPTH         bundle queue entries (power of two, >= 2)
//   UOP_BUF_SIZE  uop buffer words (power of two)
//   UOP_BITS      bits per uop
//
// Ports:
//   clk             clock
//   reset           synchronous, active-high reset
//   start           begin a routine at start_addr (honoured only in IDLE)
//   start_addr      routine entry address
//   redirect        flush the queue and restart fetch at redirect_addr
//   redirect_addr   redirect target
//   uop_addr        read address to the uop buffer (always equals pc)
//   uop_data        uops at uop_addr+i (mod buffer size) in lane i, same cycle
//   uop_end         lane i holds the last uop of the routine
//   out_valid       queue head valid
//   out_ready       decode accepts the head
//   out_uops        head bundle
//   out_lane_valid  per-lane valid of the head bundle
//   out_last        head bundle contains the routine end
//   busy            FSM not IDLE or queue non-empty
//
// Optional feature (macro UOP_FETCH_QUEUE_PERF_EN):
//   perf_stall_cycles  cycles in RUN with fetch blocked by a full queue
//   perf_bundles       dequeue handshakes
//   Both clear on reset only, survive redirect, and saturate at all-ones.
// -----------------------------------------------------------------------------
module uop_fetch_queue #(
    parameter int FETCH_WIDTH  = 2,
    parameter int DEPTH        = 4,
    parameter int UOP_BUF_SIZE = 64,
    parameter int UOP_BITS     = 32
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                start,
    input  logic [$clog2(UOP_BUF_SIZE)-1:0]     start_addr,
    input  logic                                redirect,
    input  logic [$clog2(UOP_BUF_SIZE)-1:0]     redirect_addr,
    output logic [$clog2(UOP_BUF_SIZE)-1:0]     uop_addr,
    input  logic [FETCH_WIDTH*UOP_BITS-1:0]     uop_data,
    input  logic [FETCH_WIDTH-1:0]              uop_end,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [FETCH_WIDTH*UOP_BITS-1:0]     out_uops,
    output logic [FETCH_WIDTH-1:0]              out_lane_valid,
    output logic                                out_last,
    output logic                                busy
`ifdef UOP_FETCH_QUEUE_PERF_EN
    ,
    output logic [31:0]                         perf_stall_cycles,
    output logic [31:0]                         perf_bundles
`endif
);

    localparam int AW = $clog2(UOP_BUF_SIZE);
    localparam int BW = FETCH_WIDTH * UOP_BITS;
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
    localparam logic [AW-1:0] PC_STEP    = AW'(FETCH_WIDTH);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    logic [1:0]    state;
    logic [AW-1:0] pc;

    // Bundle queue storage
    logic [BW-1:0]          q_uops       [DEPTH];
    logic [FETCH_WIDTH-1:0] q_lane_valid [DEPTH];
    logic                   q_last       [DEPTH];
    logic [PW-1:0]          head;
    logic [PW-1:0]          tail;
    logic [CW-1:0]          count;

    logic                   deq;
    logic                   fetch;
    logic                   fetch_last;
    logic [FETCH_WIDTH-1:0] fetch_lane_valid;
    logic                   end_seen;

    assign deq        = out_valid && out_ready;
    // A full queue can still accept a bundle when the head leaves this cycle.
    assign fetch      = (state == ST_RUN) && !redirect && ((count != FULL_COUNT) || deq);
    assign fetch_last = |uop_end;

    // Lanes are valid up to and including the first end-of-routine lane.
    always_comb begin
        // NOTE: default every combinational output first so no latch is inferred.
        fetch_lane_valid = '0;
        end_seen         = 1'b0;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            // NOTE: blocking assignments here, end_seen must ripple lane to lane.
            fetch_lane_valid[i] = !end_seen;
            end_seen            = end_seen | uop_end[i];
        end
    end

    // NOTE: queue storage is not reset; emptiness is tracked by count and the
    // outputs are gated below, so stale contents are never visible.
    always_ff @(posedge clk) begin
        if (!reset && fetch) begin
            q_uops[tail]       <= uop_data;
            q_lane_valid[tail] <= fetch_lane_valid;
            q_last[tail]       <= fetch_last;
        end
    end

    // Control state. Redirect outranks start, fetch and dequeue.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: non-blocking assignments for all sequential state.
            state <= ST_IDLE;
            pc    <= '0;
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (redirect) begin
            state <= ST_RUN;
            pc    <= redirect_addr;
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (deq) begin
                head <= head + PW'(1);
            end
            if (fetch) begin
                tail <= tail + PW'(1);
                pc   <= pc + PC_STEP;   // wrap by truncation
            end
            case ({fetch, deq})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state <= ST_RUN;
                        pc    <= start_addr;
                    end
                end
                ST_RUN: begin
                    if (fetch && fetch_last) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (count == '0) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign uop_addr       = pc;
    assign out_valid      = (count != '0);
    assign out_uops       = out_valid ? q_uops[head]       : '0;
    assign out_lane_valid = out_valid ? q_lane_valid[head] : '0;
    assign out_last       = out_valid ? q_last[head]       : 1'b0;
    assign busy           = (state != ST_IDLE) || out_valid;

`ifdef UOP_FETCH_QUEUE_PERF_EN
    logic stall;

    assign stall = (state == ST_RUN) && !redirect && (count == FULL_COUNT) && !deq;

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_stall_cycles <= '0;
            perf_bundles      <= '0;
        end else begin
            if (stall && (perf_stall_cycles != '1)) begin
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
            end
            if (deq && (perf_bundles != '1)) begin
                perf_bundles <= perf_bundles + 32'd1;
            end
        end
    end
`endif

endmodule
